lifo_stack: RTL

Data-path stage for the push/pop occupancy counter: an 8-bit-wide, 7-entry last-in-first-out buffer driven by the same `push`/`pop` strobes. It stores operands on push, returns them on pop, and exports an occupancy `cnt` of the same 3-bit width, plus full/empty status. Downstream logic consumes `dout`/`dout_valid`. Upstream logic uses `full`/`empty` to avoid illegal requests. Illegal requests are absorbed and flagged.

---
 rtl/lifo_pkg.sv | 27 ++
 rtl/lifo_regfile.sv | 29 ++
 rtl/lifo_stack.sv | 108 ++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared widths, depth and request opcode for the lifo_stack data path.
// decode_op turns the raw strobes plus status into one of four operations.
package lifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEPTH      = (1 << DEF_ADDR_W) - 1;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    REPLACE = 2'd3
  } lifo_op_e;

  // REPLACE covers push+pop on an empty stack too; the top level turns that into a bypass.
  function automatic lifo_op_e decode_op(input logic push, input logic pop,
                                         input logic empty, input logic full);
    lifo_op_e op;
    op = NOP;
    if (push && pop)              op = REPLACE;
    else if (push && !full)       op = PUSH;
    else if (pop && !empty)       op = POP;
    return op;
  endfunction

endpackage

// File: rtl/lifo_regfile.sv
// Stack storage: DEPTH x DATA_W registers, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module lifo_regfile
  import lifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWORDS = DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [NWORDS];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < NWORDS)) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Address NWORDS is only presented when the stack is empty; read it as zero.
  assign rdata = (int'(raddr) < NWORDS) ? r_mem[raddr] : '0;

endmodule

// File: rtl/lifo_stack.sv
// 7-entry LIFO with occupancy count doubling as stack pointer, registered pop
// data and one-cycle overflow/underflow pulses for absorbed requests.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] cnt,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int STACK_DEPTH = (1 << ADDR_W) - 1;

  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  lifo_op_e          w_op;
  logic [ADDR_W-1:0] w_top;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_full  = (r_cnt == ADDR_W'(STACK_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_op    = decode_op(push, pop, w_empty, w_full);
  assign w_top   = r_cnt - ADDR_W'(1);

  // Writes are suppressed under reset so a discarded request never lands in memory.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cnt;
    if (!reset) begin
      if (w_op == PUSH) begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
      end else if (w_op == REPLACE && !w_empty) begin
        w_we    = 1'b1;
        w_waddr = w_top;
      end
    end
  end

  lifo_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NWORDS (STACK_DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (din),
    .raddr (w_top),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_overflow   <= push && !pop && w_full;
      r_underflow  <= pop && !push && w_empty;
      case (w_op)
        PUSH: r_cnt <= r_cnt + ADDR_W'(1);
        POP: begin
          r_cnt        <= r_cnt - ADDR_W'(1);
          r_dout       <= w_rdata;
          r_dout_valid <= 1'b1;
        end
        REPLACE: begin
          // On an empty stack the pushed word passes straight through.
          r_dout       <= w_empty ? din : w_rdata;
          r_dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign cnt        = r_cnt;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
